// File: rtl/quadrature_decoder.sv
`timescale 1ns/1ps
// quadrature_decoder: synchronizes, debounces and 4x-decodes a two-channel
//   quadrature input into a wrapping signed position with step/dir/err.
// Latency: pin change sampled at edge k -> filt at k+1+DEBOUNCE_CYCLES,
//   pos/step/dir/err at k+2+DEBOUNCE_CYCLES. No backpressure: free-running.
//
// Ports:
//   clk, rst_n      12 MHz clock, asynchronous active-low reset
//   a_in, b_in      raw quadrature channels, asynchronous to clk
//   load, load_val  one-cycle strobe writing load_val into pos
//   err_clr         one-cycle strobe clearing the sticky err flag
//   pos             two's complement position, wraps modulo 2^POS_WIDTH
//   step, dir       one-cycle pulse per accepted step, direction (1 = fwd)
//   err             sticky flag: both channels changed in the same cycle
//
// Optional build macro QDEC_INDEX_EN adds z_in (raw index pulse) and index
// (one-cycle pulse when a filtered Z rising edge zeroes pos).

module quadrature_decoder #(
  parameter int DEBOUNCE_CYCLES = 1200,
  parameter int POS_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 load,
  input  logic [POS_WIDTH-1:0] load_val,
  input  logic                 err_clr,
`ifdef QDEC_INDEX_EN
  input  logic                 z_in,
  output logic                 index,
`endif
  output logic [POS_WIDTH-1:0] pos,
  output logic                 step,
  output logic                 dir,
  output logic                 err
);

  // Channel bit positions inside the per-channel vectors.
  localparam int CH_B = 0;
  localparam int CH_A = 1;
`ifdef QDEC_INDEX_EN
  localparam int CH_Z = 2;
  localparam int NCH  = 3;
`else
  localparam int NCH  = 2;
`endif

  // Debounce counters are 16 bits wide: DEBOUNCE_CYCLES is at most 65535.
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw;     // raw pins
  logic [NCH-1:0] sync1;   // first synchronizer stage
  logic [NCH-1:0] sync2;   // synchronizer output
  logic [NCH-1:0] filt;    // debounced channel levels
  logic [NCH-1:0] prev;    // filt as it was one edge ago

  logic [1:0]     prime_cnt;
  logic           primed;
  logic           prime_now;

`ifdef QDEC_INDEX_EN
  assign raw = {z_in, a_in, b_in};
`else
  assign raw = {a_in, b_in};
`endif

  // ---------------------------------------------------------------------
  // Two-flop synchronizer for every channel.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Priming: the third edge after reset release is the first one at which
  // sync2 holds a real pin sample. At that edge the filters take the pin
  // levels directly, so whatever position the encoder rests in is absorbed
  // without producing a step or an error.
  // ---------------------------------------------------------------------
  assign prime_now = !primed && (prime_cnt == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt <= 2'd0;
      primed    <= 1'b0;
    end else if (!primed) begin
      if (prime_now) begin
        primed <= 1'b1;
      end else begin
        prime_cnt <= prime_cnt + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel debounce. The counter measures how long sync has disagreed
  // with filt; any agreement restarts it, so only an uninterrupted run of
  // DEBOUNCE_CYCLES disagreeing samples moves filt.
  // ---------------------------------------------------------------------
  for (genvar ch = 0; ch < NCH; ch++) begin : g_db
    logic [15:0] cnt;
    logic        lvl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= 16'd0;
        lvl <= 1'b0;
      end else if (!primed) begin
        cnt <= 16'd0;
        if (prime_now) begin
          lvl <= sync2[ch];
        end
      end else if (sync2[ch] == lvl) begin
        cnt <= 16'd0;
      end else if (cnt == DB_LAST) begin
        lvl <= sync2[ch];
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end

    assign filt[ch] = lvl;
  end

  // prev is loaded together with filt at priming so the first decode sees
  // no movement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else if (prime_now) begin
      prev <= sync2;
    end else if (primed) begin
      prev <= filt;
    end
  end

  // ---------------------------------------------------------------------
  // Gray-code decode of the {A,B} pair.
  // Forward moves are 00->01->11->10->00. For every legal single-bit move
  // the direction reduces to old_A ^ new_B (1 = forward).
  // ---------------------------------------------------------------------
  logic [1:0] ab_prev;
  logic [1:0] ab_filt;
  logic       moved;
  logic       illegal;
  logic       legal;
  logic       fwd;
  logic       z_rise;

  assign ab_prev = {prev[CH_A], prev[CH_B]};
  assign ab_filt = {filt[CH_A], filt[CH_B]};
  assign moved   = (ab_prev != ab_filt);
  assign illegal = (ab_prev ^ ab_filt) == 2'b11;
  assign legal   = moved && !illegal;
  assign fwd     = ab_prev[1] ^ ab_filt[0];

`ifdef QDEC_INDEX_EN
  assign z_rise = !prev[CH_Z] && filt[CH_Z];
`else
  assign z_rise = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Registered outputs. Position priority: load, then index, then step.
  // A step overridden by load/index still reports step and dir.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= '0;
      step <= 1'b0;
      dir  <= 1'b0;
      err  <= 1'b0;
    end else if (primed) begin
      step <= legal;
      if (legal) begin
        dir <= fwd;
      end
      // A new illegal move wins over a simultaneous clear.
      err <= illegal || (err && !err_clr);

      if (load) begin
        pos <= load_val;
      end else if (z_rise) begin
        pos <= '0;
      end else if (legal) begin
        pos <= fwd ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
      end
    end
  end

`ifdef QDEC_INDEX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= 1'b0;
    end else if (primed) begin
      index <= z_rise && !load;
    end
  end
`endif

endmodule

// File: tb/tb_quadrature_decoder.sv
`timescale 1ns/1ps
// Testbench for quadrature_decoder (DEBOUNCE_CYCLES = 4, POS_WIDTH = 16).
// A behavioural model tracks the pin history and applies the debounce,
// Gray-order and priority rules directly; directed scenarios plus a random run.

module tb_quadrature_decoder;

  localparam int D  = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_in = 1'b0;
  logic          b_in = 1'b0;
  logic          z_drv = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] load_val = '0;
  logic          err_clr = 1'b0;
  logic [PW-1:0] pos;
  logic          step;
  logic          dir;
  logic          err;
`ifdef QDEC_INDEX_EN
  logic          index;
`endif

  int total = 0;
  int bad   = 0;

  quadrature_decoder #(.DEBOUNCE_CYCLES(D), .POS_WIDTH(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_in     (a_in),
    .b_in     (b_in),
    .load     (load),
    .load_val (load_val),
    .err_clr  (err_clr),
`ifdef QDEC_INDEX_EN
    .z_in     (z_drv),
    .index    (index),
`endif
    .pos      (pos),
    .step     (step),
    .dir      (dir),
    .err      (err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model. Channel bits: [0]=B, [1]=A, [2]=Z.
  // ---------------------------------------------------------------------
  logic [2:0]    pin_q[$];   // last three raw pin samples
  logic [2:0]    win_q[$];   // synchronized samples since priming, last D
  int            m_edge;
  logic          m_primed;
  logic [2:0]    m_filt;
  logic [2:0]    m_last;     // filtered levels one edge earlier
  logic [PW-1:0] m_pos;
  logic          m_step;
  logic          m_dir;
  logic          m_err;
  logic          m_index;

  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic model_reset();
    pin_q.delete();
    win_q.delete();
    m_edge = 0; m_primed = 1'b0; m_filt = '0; m_last = '0;
    m_pos = '0; m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0; m_index = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0]    s;
    logic [2:0]    w;
    logic [1:0]    delta;
    logic [PW-1:0] np;
    logic          ill;
    logic          all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_edge++;
    // Value presented by the synchronizer at this edge: pin from two edges ago.
    s = (pin_q.size() >= 2) ? pin_q[pin_q.size()-2] : 3'b000;
    pin_q.push_back({z_drv, a_in, b_in});
    if (pin_q.size() > 3) void'(pin_q.pop_front());
    if (!m_primed) begin
      if (m_edge == 3) begin
        m_primed = 1'b1;
        m_filt   = s;
        m_last   = s;
      end
      return;
    end
    m_step = 1'b0; m_index = 1'b0; ill = 1'b0; np = m_pos;
    if (m_last[1:0] != m_filt[1:0]) begin
      if ((m_last[1:0] ^ m_filt[1:0]) == 2'b11) begin
        ill = 1'b1;
      end else begin
        delta  = gray_pos(m_filt[1:0]) - gray_pos(m_last[1:0]);
        m_step = 1'b1;
        m_dir  = (delta == 2'd1);
        np     = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
      end
    end
    if (!m_last[2] && m_filt[2] && !load) begin
      np = '0;
      m_index = 1'b1;
    end
    if (load) np = load_val;
    m_pos  = np;
    m_err  = ill || (m_err && !err_clr);
    m_last = m_filt;
    // A channel moves once its last D synchronized samples all disagree.
    win_q.push_back(s);
    if (win_q.size() > D) void'(win_q.pop_front());
    if (win_q.size() == D) begin
      for (int ch = 0; ch < 3; ch++) begin
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) begin
          w = win_q[i];
          if (w[ch] == m_filt[ch]) all_diff = 1'b0;
        end
        if (all_diff) m_filt[ch] = s[ch];
      end
    end
  endtask

  // Advance one clock: model sees the same inputs as the DUT at the edge,
  // outputs are then sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input logic a, input logic b);
    rst_n = 1'b0; a_in = a; b_in = b; z_drv = 1'b0; load = 1'b0; err_clr = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    int steps = 0;
    do_reset(1'b1, 1'b1);
    total++;
    if ({pos, step, dir, err} !== {16'h0000, 3'b000}) begin
      bad++;
      $display("FAIL reset_vals got pos=%h step=%b dir=%b err=%b want 0000/0/0/0", pos, step, dir, err);
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step) steps++;
      if (i == 2) begin
        total++;
        if (dut.primed !== 1'b0) begin bad++; $display("FAIL primed_edge2 got=%b want=0", dut.primed); end
      end
      if (i == 3) begin
        total++;
        if (dut.primed !== 1'b1) begin bad++; $display("FAIL primed_edge3 got=%b want=1", dut.primed); end
      end
    end
    total++;
    if (steps != 0 || pos !== 16'h0000 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got steps=%0d pos=%h err=%b want 0/0000/0", steps, pos, err);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] fseq [4];
    logic [1:0] rseq [4];
    logic [1:0] ab;
    int first;
    fseq[0] = 2'b01; fseq[1] = 2'b11; fseq[2] = 2'b10; fseq[3] = 2'b00;
    rseq[0] = 2'b10; rseq[1] = 2'b11; rseq[2] = 2'b01; rseq[3] = 2'b00;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    for (int dirn = 0; dirn < 2; dirn++) begin
      for (int n = 0; n < 4; n++) begin
        ab = (dirn == 0) ? fseq[n] : rseq[n];
        a_in = ab[1]; b_in = ab[0];
        first = 0;
        for (int c = 1; c <= 20; c++) begin
          tick();
          if (step && first == 0) first = c;
          total++;
          if ({pos, step, dir, err} !== {m_pos, m_step, m_dir, m_err}) begin
            bad++;
            $display("FAIL seq_model got pos=%h step=%b dir=%b err=%b want %h/%b/%b/%b",
                     pos, step, dir, err, m_pos, m_step, m_dir, m_err);
          end
        end
        // Sampled at edge k, visible after edge k+2+D = tick D+3.
        total++;
        if (first != D + 3) begin bad++; $display("FAIL step_latency got=%0d want=%0d", first, D + 3); end
      end
      total++;
      if (dirn == 0 && (pos !== 16'd4 || dir !== 1'b1)) begin
        bad++; $display("FAIL fwd_end got pos=%h dir=%b want 0004/1", pos, dir);
      end
      if (dirn == 1 && (pos !== 16'd0 || dir !== 1'b0)) begin
        bad++; $display("FAIL rev_end got pos=%h dir=%b want 0000/0", pos, dir);
      end
    end
  endtask

  task automatic test_glitch();
    int steps = 0;
    a_in = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      tick();
      if (c == 3) a_in = 1'b0;
      if (step) steps++;
    end
    total++;
    if (steps != 0 || pos !== 16'h0000) begin
      bad++; $display("FAIL glitch3 got steps=%0d pos=%h want 0/0000", steps, pos);
    end
    steps = 0;
    a_in = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 4) a_in = 1'b0;
      if (step) steps++;
    end
    // 00 -> 10 is a reverse step; the return to 00 lands later.
    total++;
    if (steps != 1 || pos !== 16'hFFFF || dir !== 1'b0) begin
      bad++; $display("FAIL glitch4 got steps=%0d pos=%h dir=%b want 1/ffff/0", steps, pos, dir);
    end
    for (int c = 0; c < 20; c++) tick();
    total++;
    if (pos !== 16'h0000 || dir !== 1'b1) begin
      bad++; $display("FAIL glitch4_return got pos=%h dir=%b want 0000/1", pos, dir);
    end
  endtask

  task automatic test_error();
    int steps = 0;
    a_in = 1'b1; b_in = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (step) steps++;
    end
    total++;
    if (err !== 1'b1 || steps != 0 || pos !== 16'h0000) begin
      bad++; $display("FAIL illegal got err=%b steps=%0d pos=%h want 1/0/0000", err, steps, pos);
    end
    a_in = 1'b0; b_in = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL clr_vs_illegal got err=%b want 1", err); end
    for (int c = 0; c < 5; c++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0 || pos !== 16'h0000) begin
      bad++; $display("FAIL err_clr got err=%b pos=%h want 0/0000", err, pos);
    end
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 16'hFFFF;
    tick();
    load = 1'b0;
    total++;
    if (pos !== 16'hFFFF) begin bad++; $display("FAIL load got pos=%h want ffff", pos); end
    a_in = 1'b0; b_in = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    total++;
    if (pos !== 16'h0000 || dir !== 1'b1) begin
      bad++; $display("FAIL wrap_up got pos=%h dir=%b want 0000/1", pos, dir);
    end
    a_in = 1'b1; b_in = 1'b1;
    for (int c = 0; c < D + 2; c++) tick();
    load = 1'b1; load_val = 16'h1234;
    tick();
    load = 1'b0;
    total++;
    if (pos !== 16'h1234 || step !== 1'b1 || dir !== 1'b1) begin
      bad++; $display("FAIL load_vs_step got pos=%h step=%b dir=%b want 1234/1/1", pos, step, dir);
    end
    load = 1'b1; load_val = 16'h0000;
    tick();
    load = 1'b0;
    a_in = 1'b1; b_in = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    total++;
    if (pos !== 16'h0001) begin bad++; $display("FAIL fwd_from_zero got pos=%h want 0001", pos); end
    a_in = 1'b1; b_in = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    a_in = 1'b0; b_in = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    a_in = 1'b0; b_in = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    a_in = 1'b1; b_in = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    total++;
    if (pos !== 16'hFFFD) begin bad++; $display("FAIL wrap_down got pos=%h want fffd", pos); end
  endtask

`ifdef QDEC_INDEX_EN
  task automatic test_index();
    int pulses = 0;
    load = 1'b1; load_val = 16'h0123;
    tick();
    load = 1'b0;
    z_drv = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (index) pulses++;
    end
    total++;
    if (pos !== 16'h0000 || pulses != 1) begin
      bad++; $display("FAIL index got pos=%h pulses=%0d want 0000/1", pos, pulses);
    end
    z_drv = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    pulses = 0;
    z_drv = 1'b1;
    for (int c = 0; c < D + 2; c++) tick();
    load = 1'b1; load_val = 16'h0055;
    tick();
    load = 1'b0;
    if (index) pulses++;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (index) pulses++;
    end
    total++;
    if (pos !== 16'h0055 || pulses != 0) begin
      bad++; $display("FAIL index_vs_load got pos=%h pulses=%0d want 0055/0", pos, pulses);
    end
    z_drv = 1'b0;
    for (int c = 0; c < 10; c++) tick();
  endtask
`endif

  task automatic test_random();
    int r;
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) a_in = ~a_in;
      else if (r < 8) b_in = ~b_in;
      else if (r == 8) begin a_in = ~a_in; b_in = ~b_in; end
`ifdef QDEC_INDEX_EN
      if ($urandom_range(0, 5) == 0) z_drv = ~z_drv;
`endif
      hold = int'($urandom_range(1, 10));
      for (int c = 0; c < hold; c++) begin
        load     = ($urandom_range(0, 29) == 0);
        load_val = 16'($urandom);
        err_clr  = ($urandom_range(0, 19) == 0);
        tick();
        total++;
        if ({pos, step, dir, err} !== {m_pos, m_step, m_dir, m_err}) begin
          bad++;
          $display("FAIL random_model got pos=%h step=%b dir=%b err=%b want %h/%b/%b/%b",
                   pos, step, dir, err, m_pos, m_step, m_dir, m_err);
        end
`ifdef QDEC_INDEX_EN
        total++;
        if (index !== m_index) begin bad++; $display("FAIL random_index got=%b want=%b", index, m_index); end
`endif
      end
    end
    load = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int steps = 0;
    load = 1'b1; load_val = 16'h00AA;
    tick();
    load = 1'b0;
    a_in = 1'b1; b_in = 1'b0; z_drv = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({pos, step, dir, err} !== {16'h0000, 3'b000} || dut.primed !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got pos=%h step=%b dir=%b err=%b primed=%b want 0000/0/0/0/0",
               pos, step, dir, err, dut.primed);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (step) steps++;
    end
    total++;
    if (steps != 0 || pos !== 16'h0000 || err !== 1'b0) begin
      bad++; $display("FAIL reset_mid_absorb got steps=%0d pos=%h err=%b want 0/0000/0", steps, pos, err);
    end
    // 10 -> 11 is reverse from the absorbed position.
    b_in = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    total++;
    if (pos !== 16'hFFFF || dir !== 1'b0) begin
      bad++; $display("FAIL reset_mid_step got pos=%h dir=%b want ffff/0", pos, dir);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequence();
    test_glitch();
    test_error();
    test_load();
`ifdef QDEC_INDEX_EN
    test_index();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
